// File: rtl/uartlite_ctrl.sv
// uartlite_ctrl: UART-lite register block.
// Rx/Tx FIFOs, status/ctrl regs, Tx sequencer, interrupt.
module uartlite_ctrl #(
  parameter int Param_PayloadBits = 8,
  parameter int Param_FifoDepth   = 16
) (
  input  logic                         IO_Clk_I,
  input  logic                         IO_Rst_I,
  input  logic [3:0]                   Bus_Addr_I,
  input  logic                         Bus_Rd_I,
  input  logic                         Bus_Wr_I,
  input  logic [31:0]                  Bus_WData_I,
  output logic [31:0]                  Bus_RData_O,
  input  logic                         Rx_Done_I,
  input  logic [Param_PayloadBits-1:0] Rx_Data_I,
  output logic                         Tx_Start_O,
  output logic [Param_PayloadBits-1:0] Tx_Data_O,
  input  logic                         Tx_Busy_I,
  output logic                         Irq_O
);

  localparam int AW = $clog2(Param_FifoDepth);
  localparam int PB = Param_PayloadBits;
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WBUSY = 2'd1;
  localparam logic [1:0] S_WDONE = 2'd2;

  logic unused_bits;
  assign unused_bits = ^{Bus_Addr_I[1:0], Bus_WData_I};

  logic sel_rx, sel_tx, sel_st, sel_ctl;
  assign sel_rx  = (Bus_Addr_I[3:2] == 2'd0);
  assign sel_tx  = (Bus_Addr_I[3:2] == 2'd1);
  assign sel_st  = (Bus_Addr_I[3:2] == 2'd2);
  assign sel_ctl = (Bus_Addr_I[3:2] == 2'd3);

  logic rd_rx, rd_st, wr_tx, wr_ctl;
  assign rd_rx  = Bus_Rd_I & sel_rx;
  assign rd_st  = Bus_Rd_I & sel_st;
  assign wr_tx  = Bus_Wr_I & sel_tx;
  assign wr_ctl = Bus_Wr_I & sel_ctl;

  logic clr_tx, clr_rx;
  assign clr_tx = wr_ctl & Bus_WData_I[0];
  assign clr_rx = wr_ctl & Bus_WData_I[1];

  logic [PB-1:0] rx_mem_q [Param_FifoDepth];
  logic [PB-1:0] tx_mem_q [Param_FifoDepth];

  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;

  logic rx_empty, rx_full, rx_pop, rx_push, rx_ovf;
  logic tx_empty, tx_full, tx_pop, tx_push;
  logic [PB-1:0] rx_head, tx_head;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0])
                  & (rx_wp_q[AW] != rx_rp_q[AW]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0])
                  & (tx_wp_q[AW] != tx_rp_q[AW]);

  assign rx_head = rx_mem_q[rx_rp_q[AW-1:0]];
  assign tx_head = tx_mem_q[tx_rp_q[AW-1:0]];

  // A pop frees a slot for a push landing on the same edge.
  assign rx_pop  = rd_rx & ~rx_empty;
  assign rx_push = Rx_Done_I & (~rx_full | rx_pop);
  assign rx_ovf  = Rx_Done_I & rx_full & ~rx_pop;
  assign tx_push = wr_tx & (~tx_full | tx_pop);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          start_q;
  logic [PB-1:0] txd_q, txd_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ovr_q, ovr_d;
  logic          ien_q, ien_d;
  logic          irq_q, irq_d;

  // FIFO pointer update; a Ctrl reset overrides push/pop.
  always_comb begin
    rx_wp_d = rx_wp_q;
    rx_rp_d = rx_rp_q;
    tx_wp_d = tx_wp_q;
    tx_rp_d = tx_rp_q;
    if (rx_push) rx_wp_d = rx_wp_q + PtrOne;
    if (rx_pop)  rx_rp_d = rx_rp_q + PtrOne;
    if (tx_push) tx_wp_d = tx_wp_q + PtrOne;
    if (tx_pop)  tx_rp_d = tx_rp_q + PtrOne;
    if (clr_rx) begin
      rx_wp_d = '0;
      rx_rp_d = '0;
    end
    if (clr_tx) begin
      tx_wp_d = '0;
      tx_rp_d = '0;
    end
  end

  // Tx sequencer: hand one byte at a time to the engine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = S_WBUSY;
          cnt_d   = 2'd0;
        end
      end
      S_WBUSY: begin
        if (Tx_Busy_I) begin
          state_d = S_WDONE;
        end else if (cnt_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WDONE: begin
        if (!Tx_Busy_I) begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            state_d = S_WBUSY;
            cnt_d   = 2'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [31:0] status;
  assign status = {26'd0, ovr_q, ien_q, tx_full,
                   tx_empty, rx_full, ~rx_empty};

  // Registered read data; holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (Bus_Rd_I) begin
      unique case (1'b1)
        sel_rx:  rdata_d = rx_empty ? '0 : 32'(rx_head);
        sel_st:  rdata_d = status;
        default: rdata_d = '0;
      endcase
    end
  end

  logic rx_rise, tx_drain;
  assign rx_rise  = rx_empty & (rx_wp_d != rx_rp_d);
  assign tx_drain = tx_pop & (tx_wp_d == tx_rp_d);

  assign irq_d = ien_q & (rx_rise | tx_drain);
  assign ovr_d = rx_ovf | (ovr_q & ~rd_st);
  assign ien_d = wr_ctl ? Bus_WData_I[4] : ien_q;
  assign txd_d = tx_pop ? tx_head : txd_q;

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge IO_Clk_I) begin
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= Rx_Data_I;
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= Bus_WData_I[PB-1:0];
  end

  // Control state and registered outputs.
  always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
    if (!IO_Rst_I) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      txd_q   <= '0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      ien_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= tx_pop;
      txd_q   <= txd_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ien_q   <= ien_d;
      irq_q   <= irq_d;
    end
  end

  assign Bus_RData_O = rdata_q;
  assign Tx_Start_O  = start_q;
  assign Tx_Data_O   = txd_q;
  assign Irq_O       = irq_q;

endmodule

// File: tb/tb_uartlite_ctrl.sv
// tb_uartlite_ctrl: directed stimulus, queue-based model,
// per-cycle compare plus literal spot checks.
module tb_uartlite_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uartlite_ctrl #(.Param_PayloadBits(8), .Param_FifoDepth(DEPTH)) dut (
    .IO_Clk_I   (clk),
    .IO_Rst_I   (rst_n),
    .Bus_Addr_I (addr),
    .Bus_Rd_I   (rd),
    .Bus_Wr_I   (wr),
    .Bus_WData_I(wdata),
    .Bus_RData_O(rdata),
    .Rx_Done_I  (rx_done),
    .Rx_Data_I  (rx_data),
    .Tx_Start_O (tx_start),
    .Tx_Data_O  (tx_data),
    .Tx_Busy_I  (tx_busy),
    .Irq_O      (irq)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: queues for the FIFOs, transmitter
  // described as "busy with a handed byte" or "free".
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          m_ovr = 0, m_ien = 0;
  bit          m_handed = 0, m_gotbusy = 0;
  int          m_age = 0;
  logic [31:0] e_rdata = '0;
  logic        e_start = 1'b0, e_irq = 1'b0;
  logic [7:0]  e_data = '0;
  bit          m_pop, m_start, m_rxe, m_ienp, m_rxf, m_txf;
  logic [1:0]  m_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      m_ovr = 0; m_ien = 0; m_handed = 0; m_gotbusy = 0; m_age = 0;
      e_rdata = '0; e_start = 0; e_irq = 0; e_data = '0;
    end else begin
      m_sel = addr[3:2];
      if (rd) begin
        if (m_sel == 2'd0)
          e_rdata = (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0;
        else if (m_sel == 2'd2)
          e_rdata = {26'd0, m_ovr, m_ien, txq.size() == DEPTH,
                     txq.size() == 0, rxq.size() == DEPTH, rxq.size() > 0};
        else
          e_rdata = 32'd0;
      end
      m_rxe  = (rxq.size() == 0);
      m_ienp = m_ien;
      m_rxf  = (rxq.size() == DEPTH);
      m_txf  = (txq.size() == DEPTH);
      m_pop  = rd && m_sel == 2'd0 && rxq.size() > 0;
      if (m_pop) void'(rxq.pop_front());
      if (rx_done) begin
        if (!m_rxf || m_pop) rxq.push_back(rx_data);
        else m_ovr = 1;
      end else if (rd && m_sel == 2'd2) begin
        m_ovr = 0;
      end
      m_start = 0;
      if (!m_handed) begin
        m_start = txq.size() > 0;
      end else if (!m_gotbusy) begin
        if (tx_busy) m_gotbusy = 1;
        else if (m_age == 3) m_handed = 0;
        else m_age++;
      end else if (!tx_busy) begin
        if (txq.size() > 0) m_start = 1;
        else m_handed = 0;
      end
      if (m_start) begin
        e_data = txq.pop_front();
        m_handed = 1; m_gotbusy = 0; m_age = 0;
      end
      if (wr && m_sel == 2'd1 && (!m_txf || m_start))
        txq.push_back(wdata[7:0]);
      if (wr && m_sel == 2'd3) begin
        if (wdata[0]) txq.delete();
        if (wdata[1]) rxq.delete();
        m_ien = wdata[4];
      end
      e_start = m_start;
      e_irq = m_ienp && ((m_rxe && rxq.size() > 0) ||
                         (m_start && txq.size() == 0));
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdata", rdata, e_rdata);
      chk("tx_start", {31'd0, tx_start}, {31'd0, e_start});
      chk("tx_data", {24'd0, tx_data}, {24'd0, e_data});
      chk("irq", {31'd0, irq}, {31'd0, e_irq});
    end
  end

  // UartTx stand-in: 0 normal (10 busy cycles), 1 stuck, 2 absent.
  int mode = 0;
  int busy_cnt = 0;
  int irq_cnt = 0;
  int st_cyc[$];
  logic [7:0] st_dat[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      tx_busy = 1'b0;
    end else begin
      if (irq) irq_cnt++;
      if (tx_start) begin
        st_cyc.push_back(cyc);
        st_dat.push_back(tx_data);
      end
      case (mode)
        1: tx_busy = 1'b1;
        2: tx_busy = 1'b0;
        default: begin
          tx_busy = (busy_cnt > 0);
          if (busy_cnt > 0) busy_cnt--;
          if (tx_start) busy_cnt = 10;
        end
      endcase
    end
  end

  task automatic step(input bit r, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input bit rxd,
                      input logic [7:0] rb);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; rx_done = rxd; rx_data = rb;
    @(negedge clk);
    rd = 0; wr = 0; rx_done = 0;
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
    step(1, 0, a, 32'd0, 0, 8'd0);
    d = rdata;
  endtask

  task automatic wrreg(input logic [3:0] a, input logic [31:0] d);
    step(0, 1, a, d, 0, 8'd0);
  endtask

  task automatic rxbyte(input logic [7:0] b);
    step(0, 0, 4'h0, 32'd0, 1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  int b0, i0, n;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_txdata", {24'd0, tx_data}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rdreg(4'h8, v); chk("rst_status", v, 32'h4);

    rxbyte(8'h41); rxbyte(8'h42);
    rdreg(4'h0, v); chk("rx_first", v, 32'h41);
    rdreg(4'h0, v); chk("rx_second", v, 32'h42);
    rdreg(4'h8, v); chk("rx_drained", v, 32'h4);
    rdreg(4'h0, v); chk("rx_empty_rd", v, 32'h0);
    rdreg(4'h4, v); chk("rd_txreg", v, 32'h0);

    b0 = st_cyc.size();
    wrreg(4'h4, 32'h55); wrreg(4'h4, 32'hAA);
    idle(40);
    chk("seq_count", st_cyc.size() - b0, 2);
    if (st_cyc.size() >= b0 + 2) begin
      chk("seq_d0", {24'd0, st_dat[b0]}, 32'h55);
      chk("seq_d1", {24'd0, st_dat[b0+1]}, 32'hAA);
      chk("seq_gap", st_cyc[b0+1] - st_cyc[b0], 12);
    end

    mode = 2;
    b0 = st_cyc.size();
    wrreg(4'h4, 32'hC1); wrreg(4'h4, 32'hC2);
    idle(20);
    chk("tmo_count", st_cyc.size() - b0, 2);
    if (st_cyc.size() >= b0 + 2)
      chk("tmo_gap", st_cyc[b0+1] - st_cyc[b0], 5);
    mode = 0;
    idle(2);

    wrreg(4'hC, 32'h10);
    i0 = irq_cnt;
    rxbyte(8'h33); idle(3);
    chk("irq_rx", irq_cnt - i0, 1);
    rdreg(4'h0, v); chk("irq_rx_data", v, 32'h33);
    i0 = irq_cnt;
    wrreg(4'h4, 32'h77); idle(20);
    chk("irq_tx", irq_cnt - i0, 1);
    wrreg(4'hC, 32'h00);
    i0 = irq_cnt;
    rxbyte(8'h34); wrreg(4'h4, 32'h78); idle(20);
    chk("irq_off", irq_cnt - i0, 0);
    rdreg(4'h0, v); chk("irq_off_data", v, 32'h34);

    mode = 1;
    idle(1);
    wrreg(4'h4, 32'hA0);
    idle(3);
    b0 = st_cyc.size();
    wrreg(4'h4, 32'hA1); wrreg(4'h4, 32'hA2);
    chk("stall_data", {24'd0, tx_data}, 32'hA0);
    for (int i = 0; i < 17; i++) rxbyte(8'(i));
    rdreg(4'h8, v); chk("ovr_status", v, 32'h23);
    rdreg(4'h8, v); chk("ovr_clear", v, 32'h03);
    step(1, 0, 4'h0, 32'd0, 1, 8'h99);
    chk("full_rdwr", rdata, 32'h00);
    rdreg(4'h8, v); chk("full_noovr", v, 32'h03);
    n = 0;
    for (int i = 1; i < 16; i++) begin
      rdreg(4'h0, v);
      if (v == i) n++;
    end
    chk("drain_cnt", n, 15);
    rdreg(4'h0, v); chk("drain_last", v, 32'h99);
    rdreg(4'h0, v); chk("drain_empty", v, 32'h0);
    rdreg(4'h8, v); chk("tx_part", v, 32'h00);
    for (int i = 0; i < 14; i++) wrreg(4'h4, 32'hB0 + i);
    rdreg(4'h8, v); chk("tx_full", v, 32'h08);
    wrreg(4'h4, 32'hEE);
    wrreg(4'hC, 32'h01);
    rdreg(4'h8, v); chk("tx_reset", v, 32'h04);
    chk("tx_kept", {24'd0, tx_data}, 32'hA0);
    mode = 0;
    idle(10);
    chk("no_restart", st_cyc.size() - b0, 0);

    wrreg(4'h4, 32'h10);
    n = 0;
    while (!tx_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_start_seen", {31'd0, tx_start}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_start", {31'd0, tx_start}, 32'd0);
    chk("mid_data", {24'd0, tx_data}, 32'd0);
    chk("mid_irq", {31'd0, irq}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    rdreg(4'h8, v); chk("mid_status", v, 32'h4);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
